// File: rtl/ssp_pkg.sv
// ssp_pkg: definitions shared by the SSP receive, transmit and FIFO blocks.
package ssp_pkg;

   // Default frame/word width used across the SSP.
   localparam int unsigned SSP_DATA_W = 8;

   // Receive framing FSM states.
   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } ssp_rx_state_e;

endpackage

// File: rtl/ssp_sync_edge.sv
// ssp_sync_edge: multi-flop synchroniser for one asynchronous line, with a
// one-cycle pulse on each synchronised rising edge.
module ssp_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clr_b,
   input  logic din,
   output logic dout,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchroniser chain plus one delay flop for edge detection.
   always_ff @(posedge clk) begin
      if (!clr_b) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ssp_rx_shifter.sv
// ssp_rx_shifter: SSP receive front-end. Synchronises the external serial
// clock, frame sync and data into pclk, deserialises MSB-first TI-style
// frames and hands each word to the receive FIFO with a one-cycle strobe.
// Define SSP_RX_PARITY_EN to expect a trailing even-parity bit per frame
// and to add the sticky rx_parity_err output.
module ssp_rx_shifter
   import ssp_pkg::*;
#(
   parameter int unsigned DATA_W      = SSP_DATA_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              pclk,
   input  logic              clr_b,
   input  logic              sspclkin,
   input  logic              sspfssin,
   input  logic              ssprxd,
   input  logic              flag_full,
   output logic [DATA_W-1:0] rxdata,
   output logic              read_en,
   output logic              rx_busy,
   output logic              rx_overrun
`ifdef SSP_RX_PARITY_EN
   ,
   output logic              rx_parity_err
`endif
);

`ifdef SSP_RX_PARITY_EN
   localparam int unsigned FrameBits = DATA_W + 1;
`else
   localparam int unsigned FrameBits = DATA_W;
`endif
   localparam int unsigned     CntW    = $clog2(FrameBits);
   localparam logic [CntW-1:0] CntLast = CntW'(FrameBits - 1);

   logic sclk_rise, fss_s, rxd_s;
   logic sclk_s_unused, fss_rise_unused, rxd_rise_unused;

   ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk   (pclk),
      .clr_b (clr_b),
      .din   (sspclkin),
      .dout  (sclk_s_unused),
      .rise  (sclk_rise)
   );

   ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fss (
      .clk   (pclk),
      .clr_b (clr_b),
      .din   (sspfssin),
      .dout  (fss_s),
      .rise  (fss_rise_unused)
   );

   ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rxd (
      .clk   (pclk),
      .clr_b (clr_b),
      .din   (ssprxd),
      .dout  (rxd_s),
      .rise  (rxd_rise_unused)
   );

   ssp_rx_state_e     state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] rxdata_q, rxdata_d;
   logic              rearm_q, rearm_d;
   logic              overrun_q, overrun_d;
`ifdef SSP_RX_PARITY_EN
   logic              par_q, par_d;
   logic              perr_q, perr_d;
`endif

   // State and datapath registers.
   always_ff @(posedge pclk) begin
      if (!clr_b) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         shift_q   <= '0;
         rxdata_q  <= '0;
         rearm_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef SSP_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         rxdata_q  <= rxdata_d;
         rearm_q   <= rearm_d;
         overrun_q <= overrun_d;
`ifdef SSP_RX_PARITY_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   // Framing FSM: next state, shifting, word delivery and error flags.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      rxdata_d  = rxdata_q;
      rearm_d   = rearm_q;
      overrun_d = overrun_q;
      read_en   = 1'b0;
`ifdef SSP_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = perr_q;
`endif
      unique case (state_q)
         StIdle: begin
            // The sync rise carries no data bit.
            if (sclk_rise && fss_s) begin
               state_d = StShift;
               cnt_d   = '0;
               rearm_d = 1'b0;
            end
         end
         StShift: begin
            if (sclk_rise) begin
               if (fss_s && (cnt_q != CntLast)) begin
                  // Early sync restarts the frame; partial word is dropped.
                  cnt_d = '0;
               end else begin
`ifdef SSP_RX_PARITY_EN
                  if (cnt_q == CntLast) begin
                     par_d = rxd_s;
                  end else begin
                     shift_d = {shift_q[DATA_W-2:0], rxd_s};
                  end
`else
                  shift_d = {shift_q[DATA_W-2:0], rxd_s};
`endif
                  if (cnt_q == CntLast) begin
                     state_d = StDone;
                     // Sync on the last bit chains straight into the next frame.
                     rearm_d = fss_s;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         StDone: begin
`ifdef SSP_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
               perr_d = 1'b1;
            end else if (flag_full) begin
               overrun_d = 1'b1;
            end else begin
               rxdata_d = shift_q;
               read_en  = 1'b1;
            end
`else
            if (flag_full) begin
               overrun_d = 1'b1;
            end else begin
               rxdata_d = shift_q;
               read_en  = 1'b1;
            end
`endif
            cnt_d   = '0;
            rearm_d = 1'b0;
            state_d = rearm_q ? StShift : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign rxdata     = rxdata_q;
   assign rx_busy    = (state_q != StIdle);
   assign rx_overrun = overrun_q;
`ifdef SSP_RX_PARITY_EN
   assign rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_ssp_rx_shifter.sv
// tb_ssp_rx_shifter: randomized and directed self-checking bench for the SSP
// receive shifter, with a frame-level reference model.
module tb_ssp_rx_shifter;

   localparam int unsigned DATA_W = 8;

   logic              pclk = 1'b0;
   logic              clr_b = 1'b0;
   logic              sspclkin = 1'b0;
   logic              sspfssin = 1'b0;
   logic              ssprxd = 1'b0;
   logic              flag_full = 1'b0;
   logic [DATA_W-1:0] rxdata;
   logic              read_en;
   logic              rx_busy;
   logic              rx_overrun;
`ifdef SSP_RX_PARITY_EN
   logic              rx_parity_err;
`endif

   ssp_rx_shifter #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
      .pclk          (pclk),
      .clr_b         (clr_b),
      .sspclkin      (sspclkin),
      .sspfssin      (sspfssin),
      .ssprxd        (ssprxd),
      .flag_full     (flag_full),
      .rxdata        (rxdata),
      .read_en       (read_en),
      .rx_busy       (rx_busy),
      .rx_overrun    (rx_overrun)
`ifdef SSP_RX_PARITY_EN
      ,
      .rx_parity_err (rx_parity_err)
`endif
   );

   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (frame level).
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_rxdata = '0;
   logic              exp_overrun = 1'b0;
   logic              exp_perr = 1'b0;
   logic              chain_next = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Strobe monitor: each strobe must match the next expected word, be one
   // cycle wide, and publish that word on rxdata.
   logic              pend = 1'b0;
   logic [DATA_W-1:0] pend_word = '0;
   logic              pend_busy = 1'b0;
   always @(negedge pclk) begin
      if (pend) begin
         chk("rxdata_after_strobe", 32'(rxdata), 32'(pend_word));
         chk("strobe_one_cycle", 32'(read_en), 32'd0);
         chk("busy_after_strobe", 32'(rx_busy), 32'(pend_busy));
         pend = 1'b0;
      end else if (read_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 32'(read_en), 32'd0);
         end else begin
            pend_word = exp_q.pop_front();
            pend_busy = chain_next;
            pend = 1'b1;
         end
      end
   end

   task automatic send_bit(input logic fss, input logic d);
      @(negedge pclk);
      sspfssin = fss;
      ssprxd   = d;
      sspclkin = 1'b0;
      repeat (3) @(negedge pclk);
      sspclkin = 1'b1;
      repeat (4) @(negedge pclk);
   endtask

   // Model update for a completed frame; called just before its last bit.
   task automatic model_complete(input logic [DATA_W-1:0] data, input logic full,
                                 input logic par_ok);
      if (!par_ok) begin
         exp_perr = 1'b1;
      end else if (full) begin
         exp_overrun = 1'b1;
      end else begin
         exp_q.push_back(data);
         exp_rxdata = data;
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] data, input logic sync,
                             input logic rearm, input logic full, input logic par_ok);
      logic last;
      flag_full = full;
      if (sync) begin
         send_bit(1'b1, 1'($urandom_range(1, 0)));
         chk("busy_in_frame", 32'(rx_busy), 32'd1);
      end
      for (int i = DATA_W - 1; i >= 0; i--) begin
`ifdef SSP_RX_PARITY_EN
         last = 1'b0;
`else
         last = (i == 0);
`endif
         if (last) begin
            chain_next = rearm;
            model_complete(data, full, par_ok);
         end
         send_bit(last ? rearm : 1'b0, data[i]);
      end
`ifdef SSP_RX_PARITY_EN
      chain_next = rearm;
      model_complete(data, full, par_ok);
      send_bit(rearm, par_ok ? ^data : ~^data);
`endif
   endtask

   task automatic send_partial(input int nbits);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < nbits; i++) send_bit(1'b0, 1'($urandom_range(1, 0)));
   endtask

   task automatic idle_check(input string tag);
      sspfssin = 1'b0;
      repeat (8) @(negedge pclk);
      flag_full = 1'b0;
      chk({tag, "_strobes_missing"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_rxdata"}, 32'(rxdata), 32'(exp_rxdata));
      chk({tag, "_overrun"}, 32'(rx_overrun), 32'(exp_overrun));
      chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
`ifdef SSP_RX_PARITY_EN
      chk({tag, "_parity_err"}, 32'(rx_parity_err), 32'(exp_perr));
`endif
   endtask

   task automatic do_reset();
      @(negedge pclk);
      clr_b = 1'b0;
      exp_q.delete();
      exp_rxdata  = '0;
      exp_overrun = 1'b0;
      exp_perr    = 1'b0;
      repeat (2) @(negedge pclk);
      chk("rst_rxdata", 32'(rxdata), 32'd0);
      chk("rst_read_en", 32'(read_en), 32'd0);
      chk("rst_busy", 32'(rx_busy), 32'd0);
      chk("rst_overrun", 32'(rx_overrun), 32'd0);
`ifdef SSP_RX_PARITY_EN
      chk("rst_parity_err", 32'(rx_parity_err), 32'd0);
`endif
      clr_b = 1'b1;
   endtask

   initial begin
      logic armed;
      logic [DATA_W-1:0] d;
      logic rearm, full, pok;
      int kind;

      do_reset();
      idle_check("reset_idle");

      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_check("single_a5");

      send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check("b2b");

      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
      idle_check("overrun");
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_check("overrun_sticky");

      send_partial(4);
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_check("restart");

      send_partial(5);
      do_reset();
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_check("reset_mid");

`ifdef SSP_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_check("parity_ok");
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check("parity_bad");
`endif

      // Randomized frame sequences.
      armed = 1'b0;
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(9, 0));
         if (!armed && kind == 0) begin
            send_partial(int'($urandom_range(DATA_W - 2, 0)));
         end else if (!armed && kind == 1) begin
            send_partial(int'($urandom_range(DATA_W - 2, 1)));
            do_reset();
            idle_check("rnd_reset");
            continue;
         end
         d     = DATA_W'($urandom);
         rearm = ($urandom_range(2, 0) == 0);
         full  = ($urandom_range(5, 0) == 0);
`ifdef SSP_RX_PARITY_EN
         pok   = ($urandom_range(5, 0) != 0);
`else
         pok   = 1'b1;
`endif
         send_frame(d, !armed, rearm, full, pok);
         armed = rearm;
         if (!armed) idle_check("rnd");
      end
      if (armed) begin
         send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1);
         idle_check("rnd_tail");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ssp_rx_shifter.md
Name: ssp_rx_shifter

Overview:
- Receive front-end of the SSP.
- Samples the external serial clock, frame sync and data lines in the pclk domain.
- Deserialises 8-bit frames (MSB first, TI synchronous-serial framing) into parallel words.
- Delivers each word to the downstream receive FIFO as rxdata plus a one-cycle read_en strobe, and flags overrun when the FIFO reports full.

Parameters:
- DATA_W, 8: frame/word width in bits.
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers (minimum 2).

Ports:
- pclk  input  1  system clock; all state updates on its rising edge.
- clr_b  input  1  reset; synchronous, active-low.
- sspclkin  input  1  external serial clock, asynchronous to pclk.
- sspfssin  input  1  external frame sync, active-high, asynchronous.
- ssprxd  input  1  external serial data, asynchronous.
- flag_full  input  1  downstream FIFO full indication.
- rxdata  output  DATA_W  last completed word; held until the next completed word.
- read_en  output  1  one-pclk write strobe to the downstream FIFO.
- rx_busy  output  1  high while a frame is in progress.
- rx_overrun  output  1  sticky: a word was dropped because flag_full was high.

Behaviour:
- Reset: pclk with clr_b=0 clears the synchronisers, shift register, bit counter, FSM (to IDLE), rxdata=0, read_en=0, rx_busy=0 and rx_overrun=0. This applies in any state; a partial frame is discarded with no strobe.
- Synchronisation: sspclkin, sspfssin and ssprxd each pass through SYNC_STAGES flops. A rise event (sclk_rise) is one pclk wide, SYNC_STAGES+1 pclk after the external edge. fss_s and rxd_s are read at that same pclk.
- Input constraint: sspclkin high and low phases are each at least 2 pclk periods. Faster clocks are outside spec.
- FSM states:
  - IDLE: on sclk_rise with fss_s=1, go to SHIFT, cnt=0. Otherwise stay.
  - SHIFT: on sclk_rise, shift = {shift[DATA_W-2:0], rxd_s} and cnt += 1.
    - At cnt==DATA_W-1 the word is complete: go to DONE, or re-arm (below).
    - fss_s=1 at a rise with cnt<DATA_W-1 restarts the frame. That rise is the sync, not data; cnt=0 and the partial word is dropped with no strobe.
  - DONE (one pclk): if flag_full=0, rxdata<=shift and read_en=1 for exactly this cycle. If flag_full=1, rxdata is unchanged, read_en stays 0 and rx_overrun<=1. Then go to IDLE, or to SHIFT if re-armed.
- Back-to-back frames: fss_s=1 on the rise that captures the last bit sets a re-arm flag. DONE then goes straight to SHIFT with cnt=0 and no lost bits.
- read_en returns to 0 between words; consecutive strobes are at least DATA_W sclk rises apart. This gives the FIFO a clean 0→1 edge per word.
- rx_busy = (state != IDLE).
- rx_overrun clears only on reset.
- Counter width is $clog2(DATA_W). No arithmetic wrap beyond DATA_W-1 occurs.

Optional Feature:
- Macro: SSP_RX_PARITY_EN.
- Defined:
  - Each frame carries DATA_W data bits plus 1 trailing even-parity bit, so completion is at bit DATA_W.
  - Adds output rx_parity_err (1 bit, sticky, reset 0).
  - In DONE, a parity mismatch drops the word: no read_en, rxdata unchanged, rx_parity_err<=1.
  - On mismatch the overrun check is skipped.
- Undefined: DATA_W-bit frames; no parity port or logic.

Decomposition:
- Package ssp_pkg: FSM state enum (IDLE, SHIFT, DONE) and the DATA_W default constant, shared with the FIFO and transmit side.
- Sub-module ssp_sync_edge: a SYNC_STAGES synchroniser with a rise-edge pulse output. Instantiated three times; the edge output is used only on sspclkin.

Test Plan:
- Reset then idle lines: clr_b=0 for 2 pclk, lines low → rxdata=0x00, read_en=0, rx_busy=0, rx_overrun=0.
- Single frame: fss pulse then bits 0xA5 MSB-first, flag_full=0 → exactly one read_en pulse, rxdata=0xA5; rx_busy falls the cycle after the strobe.
- Back-to-back: 0x3C then 0xC3 with fss asserted on the last bit of the first → two strobes, rxdata 0x3C then 0xC3, no idle cycle lost.
- Overrun: flag_full=1 during frame 0x5A after 0x11 was received → no strobe, rxdata stays 0x11, rx_overrun=1 and stays 1.
- Mid-frame disturbances:
  - fss after 4 bits, then full frame 0xF0 → only 0xF0 strobed.
  - clr_b=0 after 5 bits → all outputs 0, no strobe, next frame 0x81 received correctly.
- Parity (with SSP_RX_PARITY_EN):
  - 0x07 with parity bit 1 → strobe.
  - 0x07 with parity bit 0 → no strobe, rx_parity_err=1.
